// File: rtl/gps_seq_pkg.sv
// Shared types and default constants for the GPS clock-enable sequencer.
package gps_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    localparam int GPS_FAST_DIV       = 10;
    localparam int GPS_CA_CHIPS       = 1023;
    localparam int GPS_EPOCHS_PER_BIT = 20;

    // Counter width for a modulus; a modulus of 1 still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gps_ce_div.sv
// Modulo-MOD counter with enable, synchronous clear and a terminal-count strobe.
// tc is combinational so the caller can register it alongside its own outputs.
module gps_ce_div #(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         gps_clk_fast,
    input  logic         gps_rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign tc = en && (cnt == LAST);

    always_ff @(posedge gps_clk_fast or negedge gps_rst_n) begin
        if (!gps_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/gps_ce_sequencer.sv
// GPS code-clock sequencer: P-code and C/A chip enables on the fast clock,
// chip/epoch/nav-bit counting and a start/stop/done host handshake.
module gps_ce_sequencer
    import gps_seq_pkg::*;
#(
    parameter int FAST_DIV       = GPS_FAST_DIV,
    parameter int CA_CHIPS       = GPS_CA_CHIPS,
    parameter int EPOCHS_PER_BIT = GPS_EPOCHS_PER_BIT,
    parameter int EPOCH_W        = 16
) (
    input  logic               gps_clk_fast,
    input  logic               gps_rst_n,
    input  logic               locked_in,
    input  logic               start_in,
    input  logic               stop_in,
    input  logic [EPOCH_W-1:0] num_epochs_in,
    output logic               busy_out,
    output logic               done_out,
    output logic               err_out,
    output logic               code_init_out,
    output logic               ce_fast_out,
    output logic               ce_slow_out,
    output logic               epoch_out,
    output logic               bit_out,
    output logic [9:0]         chip_idx_out,
    output logic [EPOCH_W-1:0] epoch_cnt_out
);

    localparam int         DIV_W     = cnt_w(FAST_DIV);
    localparam int         BIT_W     = cnt_w(EPOCHS_PER_BIT);
    localparam logic [9:0] CHIP_LAST = 10'(CA_CHIPS - 1);

    seq_state_e         state_q, state_d;
    logic               start_acc, lock_loss, final_epoch, run_d;
    logic               slow_pre, epoch_pre, bit_pre, chip_wrap;
    logic [DIV_W-1:0]   div_phase_unused;
    logic [BIT_W-1:0]   bit_phase_unused;
    logic [EPOCH_W-1:0] target_q;

    assign final_epoch = epoch_out && (target_q != '0) &&
                         (epoch_cnt_out == target_q - EPOCH_W'(1));

    // Lock loss outranks stop, which outranks completion.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        lock_loss = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in && locked_in) begin
                    state_d   = INIT;
                    start_acc = 1'b1;
                end
            end
            INIT, RUN: begin
                if (!locked_in) begin
                    state_d   = IDLE;
                    lock_loss = 1'b1;
                end else if (stop_in) begin
                    state_d = IDLE;
                end else if (state_q == INIT) begin
                    state_d = RUN;
                end else if (final_epoch) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every strobe is decided one cycle ahead from state_d and registered.
    assign run_d     = (state_d == RUN);
    assign epoch_pre = slow_pre && (chip_idx_out == CHIP_LAST);

    gps_ce_div #(.MOD(FAST_DIV), .W(DIV_W)) u_div (
        .gps_clk_fast (gps_clk_fast),
        .gps_rst_n    (gps_rst_n),
        .en           (run_d),
        .clr          (start_acc),
        .cnt          (div_phase_unused),
        .tc           (slow_pre)
    );

    // Chip index moves after the ce_slow cycle, so it names the chip in progress.
    gps_ce_div #(.MOD(CA_CHIPS), .W(10)) u_chip (
        .gps_clk_fast (gps_clk_fast),
        .gps_rst_n    (gps_rst_n),
        .en           (ce_slow_out),
        .clr          (start_acc),
        .cnt          (chip_idx_out),
        .tc           (chip_wrap)
    );

    gps_ce_div #(.MOD(EPOCHS_PER_BIT), .W(BIT_W)) u_bit (
        .gps_clk_fast (gps_clk_fast),
        .gps_rst_n    (gps_rst_n),
        .en           (epoch_pre),
        .clr          (start_acc),
        .cnt          (bit_phase_unused),
        .tc           (bit_pre)
    );

    always_ff @(posedge gps_clk_fast or negedge gps_rst_n) begin
        if (!gps_rst_n) begin
            state_q       <= IDLE;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            err_out       <= 1'b0;
            code_init_out <= 1'b0;
            ce_fast_out   <= 1'b0;
            ce_slow_out   <= 1'b0;
            epoch_out     <= 1'b0;
            bit_out       <= 1'b0;
            target_q      <= '0;
            epoch_cnt_out <= '0;
        end else begin
            state_q       <= state_d;
            busy_out      <= (state_d == INIT) || run_d;
            done_out      <= (state_d == DONE);
            code_init_out <= (state_d == INIT);
            ce_fast_out   <= run_d;
            ce_slow_out   <= slow_pre;
            epoch_out     <= epoch_pre;
            bit_out       <= bit_pre;
            if (start_acc) begin
                err_out <= 1'b0;
            end else if (lock_loss) begin
                err_out <= 1'b1;
            end
            if (start_acc) begin
                target_q <= num_epochs_in;
            end
            // Free-run epochs saturate instead of wrapping.
            if (start_acc) begin
                epoch_cnt_out <= '0;
            end else if (chip_wrap && !(&epoch_cnt_out)) begin
                epoch_cnt_out <= epoch_cnt_out + EPOCH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gps_ce_sequencer.sv
// Self-checking bench for gps_ce_sequencer against a run-phase arithmetic model.
module tb_gps_ce_sequencer;

    localparam int FD   = 10;
    localparam int CA   = 7;
    localparam int EPB  = 2;
    localparam int EW   = 4;
    localparam int ELEN = FD * CA;
    localparam int EMAX = (1 << EW) - 1;
    localparam int OW   = 18 + EW;

    logic          gps_clk_fast = 1'b0;
    logic          gps_rst_n    = 1'b0;
    logic          locked_in    = 1'b0;
    logic          start_in     = 1'b0;
    logic          stop_in      = 1'b0;
    logic [EW-1:0] num_epochs_in = '0;
    logic          busy_out, done_out, err_out, code_init_out;
    logic          ce_fast_out, ce_slow_out, epoch_out, bit_out;
    logic [9:0]    chip_idx_out;
    logic [EW-1:0] epoch_cnt_out;

    gps_ce_sequencer #(
        .FAST_DIV(FD), .CA_CHIPS(CA), .EPOCHS_PER_BIT(EPB), .EPOCH_W(EW)
    ) dut (
        .gps_clk_fast  (gps_clk_fast),
        .gps_rst_n     (gps_rst_n),
        .locked_in     (locked_in),
        .start_in      (start_in),
        .stop_in       (stop_in),
        .num_epochs_in (num_epochs_in),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .err_out       (err_out),
        .code_init_out (code_init_out),
        .ce_fast_out   (ce_fast_out),
        .ce_slow_out   (ce_slow_out),
        .epoch_out     (epoch_out),
        .bit_out       (bit_out),
        .chip_idx_out  (chip_idx_out),
        .epoch_cnt_out (epoch_cnt_out)
    );

    always #5 gps_clk_fast = ~gps_clk_fast;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: a run is described only by k = cycles since the accepted start.
    bit m_act, m_done, m_err;
    int m_k, m_slows, m_epochs, m_tgt;

    function automatic logic [OW-1:0] observed();
        return {busy_out, done_out, err_out, code_init_out, ce_fast_out,
                ce_slow_out, epoch_out, bit_out, chip_idx_out, epoch_cnt_out};
    endfunction

    function automatic logic [OW-1:0] m_expect();
        logic bz, ci, cf, cs, ep, bt;
        bz = 0; ci = 0; cf = 0; cs = 0; ep = 0; bt = 0;
        if (m_act) begin
            bz = 1;
            if (m_k == 0) ci = 1;
            else begin
                cf = 1;
                cs = (m_k % FD == 0);
                ep = (m_k % ELEN == 0);
                bt = ep && ((m_k / ELEN) % EPB == 0);
            end
        end
        return {bz, m_done, m_err, ci, cf, cs, ep, bt, 10'(m_slows % CA), EW'(m_epochs)};
    endfunction

    task automatic m_reset();
        m_act = 0; m_done = 0; m_err = 0;
        m_k = 0; m_slows = 0; m_epochs = 0; m_tgt = 0;
    endtask

    task automatic m_step(input logic st, input logic sp, input logic lk, input logic [EW-1:0] ne);
        bit pslow, pep;
        pslow = m_act && (m_k > 0) && (m_k % FD == 0);
        pep   = m_act && (m_k > 0) && (m_k % ELEN == 0);
        if (pslow) m_slows++;
        if (pep && m_epochs < EMAX) m_epochs++;
        if (m_done) m_done = 0;
        else if (m_act) begin
            if (!lk) begin m_act = 0; m_err = 1; end
            else if (sp) m_act = 0;
            else if (pep && m_tgt != 0 && (m_k / ELEN) == m_tgt) begin m_act = 0; m_done = 1; end
            else m_k++;
        end else if (st && lk) begin
            m_act = 1; m_k = 0; m_slows = 0; m_epochs = 0; m_err = 0; m_tgt = int'(ne);
        end
    endtask

    task automatic tick(input logic st, input logic sp, input logic lk, input logic [EW-1:0] ne);
        start_in = st; stop_in = sp; locked_in = lk; num_epochs_in = ne;
        @(posedge gps_clk_fast);
        #1;
        cyc++;
        m_step(st, sp, lk, ne);
    endtask

    task automatic test_reset();
        gps_rst_n = 0; locked_in = 0; start_in = 0; stop_in = 0;
        repeat (3) @(posedge gps_clk_fast);
        #1;
        checks++;
        if (observed() !== '0) begin
            errors++; $display("FAIL reset_state got=%h exp=0", observed());
        end
        @(negedge gps_clk_fast);
        gps_rst_n = 1;
        m_reset();
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            tick(0, 1'($urandom), 1'($urandom), EW'($urandom));
            checks++;
            if (observed() !== m_expect()) begin
                errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, observed(), m_expect());
            end
        end
    endtask

    task automatic test_nominal();
        int s, ci_cyc, slow1, done_cyc, n_ep, n_bit;
        int ep_c[4];
        int bit_c[2];
        logic busy_at_done;
        ci_cyc = -1; slow1 = -1; done_cyc = -1; n_ep = 0; n_bit = 0; busy_at_done = 1'bx;
        s = cyc;
        tick(1, 0, 1, EW'(4));
        for (int i = 0; i < 300; i++) begin
            checks++;
            if (observed() !== m_expect()) begin
                errors++; $display("FAIL nominal cyc=%0d got=%h exp=%h", cyc, observed(), m_expect());
            end
            if (code_init_out && ci_cyc < 0) ci_cyc = cyc;
            if (ce_slow_out && slow1 < 0) slow1 = cyc;
            if (epoch_out && n_ep < 4) begin ep_c[n_ep] = cyc; n_ep++; end
            if (bit_out && n_bit < 2) begin bit_c[n_bit] = cyc; n_bit++; end
            if (done_out && done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy_out; end
            tick((i < 270) && ($urandom_range(0, 15) == 0), 0, 1, EW'($urandom));
        end
        checks++;
        if (ci_cyc !== s + 1) begin errors++; $display("FAIL nominal_code_init got=%0d exp=%0d", ci_cyc, s + 1); end
        checks++;
        if (slow1 !== s + 1 + FD) begin errors++; $display("FAIL nominal_first_slow got=%0d exp=%0d", slow1, s + 1 + FD); end
        checks++;
        if (n_ep !== 4) begin errors++; $display("FAIL nominal_epoch_count got=%0d exp=4", n_ep); end
        for (int m = 0; m < n_ep; m++) begin
            checks++;
            if (ep_c[m] !== s + 1 + ELEN * (m + 1)) begin
                errors++; $display("FAIL nominal_epoch%0d got=%0d exp=%0d", m, ep_c[m], s + 1 + ELEN * (m + 1));
            end
        end
        checks++;
        if (n_bit !== 2) begin errors++; $display("FAIL nominal_bit_count got=%0d exp=2", n_bit); end
        for (int m = 0; m < n_bit; m++) begin
            checks++;
            if (bit_c[m] !== s + 1 + ELEN * EPB * (m + 1)) begin
                errors++; $display("FAIL nominal_bit%0d got=%0d exp=%0d", m, bit_c[m], s + 1 + ELEN * EPB * (m + 1));
            end
        end
        checks++;
        if (done_cyc !== s + 2 + 4 * ELEN) begin errors++; $display("FAIL nominal_done got=%0d exp=%0d", done_cyc, s + 2 + 4 * ELEN); end
        checks++;
        if (busy_at_done !== 1'b0) begin errors++; $display("FAIL nominal_busy_at_done got=%b exp=0", busy_at_done); end
    endtask

    task automatic test_reset_mid_run();
        int s;
        s = cyc;
        tick(1, 0, 1, EW'(3));
        while (cyc < s + 40) begin
            checks++;
            if (observed() !== m_expect()) begin
                errors++; $display("FAIL midrun cyc=%0d got=%h exp=%h", cyc, observed(), m_expect());
            end
            tick(0, 0, 1, EW'($urandom));
        end
        #1 gps_rst_n = 0;
        #1;
        checks++;
        if (observed() !== '0) begin errors++; $display("FAIL async_reset got=%h exp=0", observed()); end
        @(negedge gps_clk_fast);
        gps_rst_n = 1;
        m_reset();
        for (int i = 0; i < 20; i++) begin
            tick(0, 1'($urandom), 1'($urandom), EW'($urandom));
            checks++;
            if (observed() !== '0) begin
                errors++; $display("FAIL post_reset_idle cyc=%0d got=%h exp=0", cyc, observed());
            end
        end
    endtask

    task automatic test_lock_loss();
        bit saw_done;
        saw_done = 0;
        tick(1, 0, 1, EW'(2));
        while (m_k < 30) begin
            checks++;
            if (observed() !== m_expect()) begin
                errors++; $display("FAIL lockloss_run cyc=%0d got=%h exp=%h", cyc, observed(), m_expect());
            end
            tick(($urandom_range(0, 7) == 0), 0, 1, EW'($urandom));
        end
        tick(0, 1, 0, EW'($urandom));
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (observed() !== m_expect()) begin
                errors++; $display("FAIL lockloss_idle cyc=%0d got=%h exp=%h", cyc, observed(), m_expect());
            end
            if (done_out) saw_done = 1;
            tick(i == 4, 0, 0, EW'($urandom));
        end
        checks++;
        if (err_out !== 1'b1 || busy_out !== 1'b0) begin
            errors++; $display("FAIL lockloss_err got err=%b busy=%b exp err=1 busy=0", err_out, busy_out);
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL lockloss_done got=1 exp=0"); end
        tick(1, 0, 1, EW'(1));
        checks++;
        if (err_out !== 1'b0 || code_init_out !== 1'b1) begin
            errors++; $display("FAIL restart_clears_err got err=%b init=%b exp err=0 init=1", err_out, code_init_out);
        end
        for (int i = 0; i < ELEN + 6; i++) begin
            tick(0, 0, 1, EW'($urandom));
            checks++;
            if (observed() !== m_expect()) begin
                errors++; $display("FAIL restart_run cyc=%0d got=%h exp=%h", cyc, observed(), m_expect());
            end
        end
    endtask

    task automatic test_free_run(input int n_ep, input int exp_cnt);
        bit saw_done;
        int stop_k;
        saw_done = 0;
        stop_k = n_ep * ELEN + 25;
        tick(1, 0, 1, EW'(0));
        while (m_k < stop_k) begin
            checks++;
            if (observed() !== m_expect()) begin
                errors++; $display("FAIL freerun cyc=%0d got=%h exp=%h", cyc, observed(), m_expect());
            end
            if (done_out) saw_done = 1;
            tick(($urandom_range(0, 31) == 0), 0, 1, EW'($urandom));
        end
        tick(0, 1, 1, EW'($urandom));
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (observed() !== m_expect()) begin
                errors++; $display("FAIL freerun_hold cyc=%0d got=%h exp=%h", cyc, observed(), m_expect());
            end
            if (done_out) saw_done = 1;
            tick(0, 1'($urandom), 1, EW'($urandom));
        end
        checks++;
        if (epoch_cnt_out !== EW'(exp_cnt)) begin
            errors++; $display("FAIL freerun_epochs got=%0d exp=%0d", epoch_cnt_out, exp_cnt);
        end
        checks++;
        if (chip_idx_out !== 10'((stop_k / FD) % CA)) begin
            errors++; $display("FAIL freerun_chip got=%0d exp=%0d", chip_idx_out, (stop_k / FD) % CA);
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL freerun_done got=1 exp=0"); end
    endtask

    task automatic test_random_runs();
        int tgt, abort_kind, abort_k;
        for (int r = 0; r < 4; r++) begin
            tgt        = $urandom_range(1, 3);
            abort_kind = $urandom_range(0, 2);
            abort_k    = $urandom_range(0, tgt * ELEN + 2);
            repeat ($urandom_range(1, 4)) tick(0, 1'($urandom), 1'($urandom), EW'($urandom));
            tick(1, 0, 1, EW'(tgt));
            for (int i = 0; i < tgt * ELEN + 10; i++) begin
                checks++;
                if (observed() !== m_expect()) begin
                    errors++; $display("FAIL random_run%0d cyc=%0d got=%h exp=%h", r, cyc, observed(), m_expect());
                end
                if (m_act && abort_kind != 0 && m_k == abort_k)
                    tick(0, (abort_kind == 1) ? 1'b1 : 1'($urandom), (abort_kind == 2) ? 1'b0 : 1'b1, EW'($urandom));
                else
                    tick(m_act && ($urandom_range(0, 19) == 0), 0, 1, EW'($urandom));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_reset_mid_run();
        test_lock_loss();
        test_free_run(10, 10);
        test_free_run(17, EMAX);
        test_random_runs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
